fetch_pack_queue: RTL and testbench
===================================

Name: fetch_pack_queue

Overview:
Parametrised successor to the fetch-to-decode packer. It accepts one fetch group of WAY instructions per cycle and packs it into per-slot PC, instruction, recovery-PC and prediction fields. It supports up to MAX_BR predicted branches per group. Packed groups are buffered in a DEPTH-entry circular queue with valid/ready handshakes on both sides, and a flush empties the queue on redirect. It sits between the fetch/branch-handler stage and decode, decoupling fetch stalls from decode stalls.

Parameters:
WAY, 4, instructions per fetch group (>=1)
PC_W, 16, PC width in bits
INST_W, 16, instruction width in bits
MAX_BR, 2, maximum branches honoured per group (1..WAY)
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous queue clear (mispredict/redirect)
in_valid  in  1  fetch group present
in_ready  out  1  queue can accept a group
pc  in  PC_W  PC of slot 0; slot i PC is pc+i
inst  in  WAY*INST_W  instructions, slot 0 in the MSBs
brnch_mask  in  WAY  slot holds a branch, bit WAY-1 = slot 0
brnch_target  in  MAX_BR*PC_W  target of the k-th branch in slot order, k=0 in the MSBs
pred  in  MAX_BR  prediction of the k-th branch (1 = taken), k=0 = MSB
nop_mask  in  WAY  slot replaced by NOP (immediate jump handled in fetch), bit WAY-1 = slot 0
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
pc_to_dec  out  WAY*PC_W  packed per-slot PCs
inst_to_dec  out  WAY*INST_W  packed instructions, NOP slots forced to 0
recv_pc_to_dec  out  WAY*PC_W  per-slot recovery PC
pred_result_to_dec  out  WAY  per-slot prediction bit
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Packing, combinational on input, stored at push:
  - pc_i = (pc+i) mod 2^PC_W.
  - inst_i = nop_mask slot ? 0 : inst slot.
  - Branch slots are ranked k=0,1,... from slot 0 upward.
  - For a ranked slot i with k<MAX_BR: recv_i = pred[k] ? brnch_target[k] : (pc+i+1) mod 2^PC_W, and pred_result_i = pred[k].
  - All other slots, including branches ranked k>=MAX_BR: recv_i = 0, pred_result_i = 0.
  - A slot set in both nop_mask and brnch_mask gets inst=0, but its recv and pred fields are still generated.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH); it is combinational from count only and does not depend on out_ready.
  - out_valid = (count != 0).
- Latency: a group pushed at edge N is visible on the outputs and out_valid after edge N, in cycle N+1. There is no bypass from input to output.
- Simultaneous push and pop: allowed whenever both are legal, and count is unchanged. At full, in_ready=0, so no push occurs even if a pop happens.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate register, or the difference of pointers extended by one bit.
- Outputs: driven from the head entry when out_valid=1. When empty, all data outputs are 0.
- Flush:
  - At the edge where flush=1, wr_ptr, rd_ptr and count go to 0.
  - Any push or pop in that cycle is discarded. Flush has priority over push and pop; rst has priority over flush.
  - Stored entry contents need not be cleared, because outputs are gated by out_valid.
- Reset: count=0, pointers=0, out_valid=0, all data outputs=0, in_ready=1 in the cycle after the reset edge. Reset asserted mid-stream discards all entries.
- Unchanged input: in_valid with in_ready=0 leaves the queue untouched. Fetch must hold its inputs stable.

Decomposition:
- Package fetch_pack_pkg holds:
  - default WAY/PC_W/INST_W/MAX_BR/DEPTH localparams;
  - the entry width ENTRY_W = WAY*(2*PC_W+INST_W+1);
  - field offset constants for slicing a stored entry.
- Sub-module fetch_group_packer: purely combinational. It does the slot ranking, recovery-PC and NOP muxing, and outputs one ENTRY_W vector.
- The top level holds the storage array, pointers, count and handshake logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, out_valid=0, in_ready=1, all data outputs 0.
- Two-branch pack: pc=0x0100, brnch_mask=4'b0101, pred=2'b10, targets 0x0200/0x0300, nop_mask=4'b0000 -> pc_to_dec={0100,0101,0102,0103}, recv={0000,0200,0000,0104}, pred_result=4'b0100 one cycle after push.
- Excess branches and NOP: brnch_mask=4'b1111, pred=2'b11, nop_mask=4'b0010 -> recv slot0/1 = targets, slot2/3 = 0, pred_result=4'b1100, slot2 instruction = 0.
- PC wrap: pc=0xFFFE, brnch_mask=4'b0001 with the branch in slot 3, pred=0 -> slot PCs FFFE,FFFF,0000,0001, recv slot3 = 0x0002.
- Fill and back-pressure: out_ready=0, push 5 groups -> count reaches 4, in_ready=0, the 5th is not accepted. Then out_ready=1 with in_valid=1 -> one pop per cycle, FIFO order preserved, count stays 3–4.
- Flush collision: with count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the pushed group is never output.

Source files
------------

// File: rtl/fetch_pack_pkg.sv
// fetch_pack_pkg
// Shared constants for the fetch-to-decode pack queue: default geometry,
// the stored entry width and helper functions that give the bit offset of
// every field inside a stored entry.
//
// Stored entry layout (MSB to LSB):
//   { pc[WAY*PC_W], inst[WAY*INST_W], recv[WAY*PC_W], pred[WAY] }
// Within each field, slot 0 occupies the most significant sub-field.
package fetch_pack_pkg;

    localparam int DEF_WAY    = 4;
    localparam int DEF_PC_W   = 16;
    localparam int DEF_INST_W = 16;
    localparam int DEF_MAX_BR = 2;
    localparam int DEF_DEPTH  = 4;

    localparam int ENTRY_W = DEF_WAY * (2 * DEF_PC_W + DEF_INST_W + 1);

    // Width of one packed group for an arbitrary geometry.
    function automatic int f_entry_w(input int way, input int pc_w, input int inst_w);
        return way * (2 * pc_w + inst_w + 1);
    endfunction

    // Field offsets (LSB position) inside a stored entry.
    function automatic int f_off_pred(input int way);
        return 0;
    endfunction

    function automatic int f_off_recv(input int way);
        return way;
    endfunction

    function automatic int f_off_inst(input int way, input int pc_w);
        return way + way * pc_w;
    endfunction

    function automatic int f_off_pc(input int way, input int pc_w, input int inst_w);
        return way + way * pc_w + way * inst_w;
    endfunction

endpackage

// File: rtl/fetch_pack_queue_if.sv
// fetch_pack_queue_if
// Bundles the fetch-side push handshake, the decode-side pop handshake and
// the packed per-slot data bus of the fetch pack queue.
//   master : fetch/decode environment (drives group inputs and out_ready)
//   slave  : the queue (drives in_ready, out_valid, packed outputs, count)
interface fetch_pack_queue_if
    import fetch_pack_pkg::*;
#(
    parameter int WAY    = DEF_WAY,
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int MAX_BR = DEF_MAX_BR,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [PC_W-1:0]          pc;
    logic [WAY*INST_W-1:0]    inst;
    logic [WAY-1:0]           brnch_mask;
    logic [MAX_BR*PC_W-1:0]   brnch_target;
    logic [MAX_BR-1:0]        pred;
    logic [WAY-1:0]           nop_mask;
    logic                     out_valid;
    logic                     out_ready;
    logic [WAY*PC_W-1:0]      pc_to_dec;
    logic [WAY*INST_W-1:0]    inst_to_dec;
    logic [WAY*PC_W-1:0]      recv_pc_to_dec;
    logic [WAY-1:0]           pred_result_to_dec;
    logic [CNT_W-1:0]         count;

    modport master (
        output in_valid, pc, inst, brnch_mask, brnch_target, pred, nop_mask, out_ready,
        input  in_ready, out_valid, pc_to_dec, inst_to_dec, recv_pc_to_dec,
               pred_result_to_dec, count
    );

    modport slave (
        input  in_valid, pc, inst, brnch_mask, brnch_target, pred, nop_mask, out_ready,
        output in_ready, out_valid, pc_to_dec, inst_to_dec, recv_pc_to_dec,
               pred_result_to_dec, count
    );

endinterface

// File: rtl/fetch_group_packer.sv
// fetch_group_packer
// Purely combinational packing of one fetch group into a queue entry.
//   pc_i, inst_i, brnch_mask_i, brnch_target_i, pred_i, nop_mask_i : fetch group
//   entry_o : {pc, inst, recv, pred} fields, slot 0 in the MSBs of each field
module fetch_group_packer
    import fetch_pack_pkg::*;
#(
    parameter int WAY    = DEF_WAY,
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int MAX_BR = DEF_MAX_BR,
    parameter int EW     = f_entry_w(WAY, PC_W, INST_W)
) (
    input  logic [PC_W-1:0]        pc_i,
    input  logic [WAY*INST_W-1:0]  inst_i,
    input  logic [WAY-1:0]         brnch_mask_i,
    input  logic [MAX_BR*PC_W-1:0] brnch_target_i,
    input  logic [MAX_BR-1:0]      pred_i,
    input  logic [WAY-1:0]         nop_mask_i,
    output logic [EW-1:0]          entry_o
);

    logic [WAY*PC_W-1:0]   pc_f_s;
    logic [WAY*INST_W-1:0] inst_f_s;
    logic [WAY*PC_W-1:0]   recv_f_s;
    logic [WAY-1:0]        pred_f_s;

    // Walk slots from slot 0 upward, ranking branch slots in order; only the
    // first MAX_BR branches consume a target/prediction pair.
    always_comb begin
        logic [PC_W-1:0] slot_pc;
        int              rank;
        int              s;
        pc_f_s   = '0;
        inst_f_s = '0;
        recv_f_s = '0;
        pred_f_s = '0;
        slot_pc  = '0;
        rank     = 0;
        s        = 0;
        for (int i = 0; i < WAY; i++) begin
            s       = WAY - 1 - i;
            slot_pc = pc_i + PC_W'(i);
            pc_f_s[s*PC_W +: PC_W] = slot_pc;
            if (nop_mask_i[s]) begin
                inst_f_s[s*INST_W +: INST_W] = {INST_W{1'b0}};
            end else begin
                inst_f_s[s*INST_W +: INST_W] = inst_i[s*INST_W +: INST_W];
            end
            // A NOP'd branch still produces recovery info; only its inst is cleared.
            if (brnch_mask_i[s]) begin
                if (rank < MAX_BR) begin
                    pred_f_s[s] = pred_i[MAX_BR-1-rank];
                    if (pred_i[MAX_BR-1-rank]) begin
                        recv_f_s[s*PC_W +: PC_W] = brnch_target_i[(MAX_BR-1-rank)*PC_W +: PC_W];
                    end else begin
                        recv_f_s[s*PC_W +: PC_W] = slot_pc + PC_W'(1);
                    end
                end else begin
                    pred_f_s[s] = 1'b0;
                    recv_f_s[s*PC_W +: PC_W] = {PC_W{1'b0}};
                end
                rank = rank + 1;
            end else begin
                pred_f_s[s] = 1'b0;
                recv_f_s[s*PC_W +: PC_W] = {PC_W{1'b0}};
            end
        end
    end

    assign entry_o = {pc_f_s, inst_f_s, recv_f_s, pred_f_s};

endmodule

// File: rtl/fetch_pack_queue.sv
// fetch_pack_queue
// DEPTH-entry circular queue of packed fetch groups between fetch and decode.
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset (highest priority)
//   flush : synchronous clear on redirect (beats push and pop)
//   q     : slave side of fetch_pack_queue_if (push/pop handshakes, packed
//           head entry outputs and occupancy count)
// A pushed group becomes visible one cycle after the push edge; there is no
// input-to-output bypass. Outputs read zero while the queue is empty.
module fetch_pack_queue
    import fetch_pack_pkg::*;
#(
    parameter int WAY    = DEF_WAY,
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W,
    parameter int MAX_BR = DEF_MAX_BR,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    fetch_pack_queue_if.slave q
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int EW       = f_entry_w(WAY, PC_W, INST_W);
    localparam int OFF_PRED = f_off_pred(WAY);
    localparam int OFF_RECV = f_off_recv(WAY);
    localparam int OFF_INST = f_off_inst(WAY, PC_W);
    localparam int OFF_PC   = f_off_pc(WAY, PC_W, INST_W);

    logic [EW-1:0]    entry_s;
    logic [EW-1:0]    head_s;
    logic             push_s;
    logic             pop_s;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    fetch_group_packer #(
        .WAY    (WAY),
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .MAX_BR (MAX_BR),
        .EW     (EW)
    ) u_packer (
        .pc_i           (q.pc),
        .inst_i         (q.inst),
        .brnch_mask_i   (q.brnch_mask),
        .brnch_target_i (q.brnch_target),
        .pred_i         (q.pred),
        .nop_mask_i     (q.nop_mask),
        .entry_o        (entry_s)
    );

    // in_ready depends on occupancy only, never on out_ready, so a full
    // queue refuses a push even in a cycle where it also pops.
    assign q.in_ready  = (count_q != CNT_W'(DEPTH));
    assign q.out_valid = (count_q != {CNT_W{1'b0}});
    assign q.count     = count_q;
    assign push_s      = q.in_valid & q.in_ready;
    assign pop_s       = q.out_valid & q.out_ready;

    // Next-state for pointers and occupancy; flush discards this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never cleared since outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    // Head entry, forced to zero while empty.
    always_comb begin
        if (q.out_valid) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = {EW{1'b0}};
        end
    end

    assign q.pc_to_dec          = head_s[OFF_PC   +: WAY*PC_W];
    assign q.inst_to_dec        = head_s[OFF_INST +: WAY*INST_W];
    assign q.recv_pc_to_dec     = head_s[OFF_RECV +: WAY*PC_W];
    assign q.pred_result_to_dec = head_s[OFF_PRED +: WAY];

endmodule

// File: tb/tb_fetch_pack_queue.sv
// tb_fetch_pack_queue
// Directed self-checking bench for fetch_pack_queue with default geometry
// (WAY=4, PC_W=16, INST_W=16, MAX_BR=2, DEPTH=4).
module tb_fetch_pack_queue;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;

    fetch_pack_queue_if q_if ();

    fetch_pack_queue dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (q_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        q_if.in_valid     = 1'b0;
        q_if.out_ready    = 1'b0;
        q_if.pc           = 16'h0000;
        q_if.inst         = 64'h1111_2222_3333_4444;
        q_if.brnch_mask   = 4'b0000;
        q_if.brnch_target = 32'h0200_0300;
        q_if.pred         = 2'b00;
        q_if.nop_mask     = 4'b0000;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_count",   64'(q_if.count), 64'd0);
        chk("rst_ovalid",  64'(q_if.out_valid), 64'd0);
        chk("rst_iready",  64'(q_if.in_ready), 64'd1);
        chk("rst_pc",      q_if.pc_to_dec, 64'd0);
        chk("rst_inst",    q_if.inst_to_dec, 64'd0);
        chk("rst_recv",    q_if.recv_pc_to_dec, 64'd0);
        chk("rst_pred",    64'(q_if.pred_result_to_dec), 64'd0);

        // Two-branch pack: slot1 taken -> 0x0200, slot3 not taken -> pc+4
        q_if.pc         = 16'h0100;
        q_if.brnch_mask = 4'b0101;
        q_if.pred       = 2'b10;
        q_if.in_valid   = 1'b1;
        step();
        q_if.in_valid = 1'b0;
        chk("b2_count", 64'(q_if.count), 64'd1);
        chk("b2_ovalid", 64'(q_if.out_valid), 64'd1);
        chk("b2_pc",    q_if.pc_to_dec, 64'h0100_0101_0102_0103);
        chk("b2_inst",  q_if.inst_to_dec, 64'h1111_2222_3333_4444);
        chk("b2_recv",  q_if.recv_pc_to_dec, 64'h0000_0200_0000_0104);
        chk("b2_pred",  64'(q_if.pred_result_to_dec), 64'h4);
        q_if.out_ready = 1'b1;
        step();
        q_if.out_ready = 1'b0;
        chk("b2_popped", 64'(q_if.count), 64'd0);
        chk("b2_empty_pc", q_if.pc_to_dec, 64'd0);

        // Excess branches plus a NOP slot
        q_if.pc         = 16'h0A00;
        q_if.brnch_mask = 4'b1111;
        q_if.pred       = 2'b11;
        q_if.nop_mask   = 4'b0010;
        q_if.in_valid   = 1'b1;
        step();
        q_if.in_valid = 1'b0;
        chk("xb_pc",   q_if.pc_to_dec, 64'h0A00_0A01_0A02_0A03);
        chk("xb_inst", q_if.inst_to_dec, 64'h1111_2222_0000_4444);
        chk("xb_recv", q_if.recv_pc_to_dec, 64'h0200_0300_0000_0000);
        chk("xb_pred", 64'(q_if.pred_result_to_dec), 64'hC);
        q_if.out_ready = 1'b1;
        step();
        q_if.out_ready = 1'b0;

        // PC wrap with the not-taken branch in slot 3
        q_if.pc         = 16'hFFFE;
        q_if.brnch_mask = 4'b0001;
        q_if.pred       = 2'b00;
        q_if.nop_mask   = 4'b0000;
        q_if.in_valid   = 1'b1;
        step();
        q_if.in_valid = 1'b0;
        chk("wrap_pc",   q_if.pc_to_dec, 64'hFFFE_FFFF_0000_0001);
        chk("wrap_recv", q_if.recv_pc_to_dec, 64'h0000_0000_0000_0002);
        chk("wrap_pred", 64'(q_if.pred_result_to_dec), 64'h0);
        q_if.out_ready = 1'b1;
        step();
        q_if.out_ready = 1'b0;
        chk("wrap_popped", 64'(q_if.count), 64'd0);

        // Fill and back-pressure
        q_if.brnch_mask = 4'b0000;
        q_if.in_valid   = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            q_if.pc = 16'(g * 16'h1000);
            step();
            chk("fill_count", 64'(q_if.count), 64'(g));
        end
        q_if.pc = 16'h5000;
        step();
        chk("full_count",  64'(q_if.count), 64'd4);
        chk("full_iready", 64'(q_if.in_ready), 64'd0);
        chk("full_head",   64'(q_if.pc_to_dec[63:48]), 64'h1000);
        q_if.out_ready = 1'b1;
        step();
        chk("drain1_count", 64'(q_if.count), 64'd3);
        chk("drain1_head",  64'(q_if.pc_to_dec[63:48]), 64'h2000);
        step();
        chk("drain2_count", 64'(q_if.count), 64'd3);
        chk("drain2_head",  64'(q_if.pc_to_dec[63:48]), 64'h3000);
        q_if.pc = 16'h6000;
        step();
        chk("drain3_count", 64'(q_if.count), 64'd3);
        chk("drain3_head",  64'(q_if.pc_to_dec[63:48]), 64'h4000);
        q_if.in_valid = 1'b0;
        step();
        chk("drain4_count", 64'(q_if.count), 64'd2);
        chk("drain4_head",  64'(q_if.pc_to_dec[63:48]), 64'h5000);
        step();
        chk("drain5_count", 64'(q_if.count), 64'd1);
        chk("drain5_head",  64'(q_if.pc_to_dec[63:48]), 64'h6000);
        step();
        chk("drain6_ovalid", 64'(q_if.out_valid), 64'd0);

        // Flush collision with push and pop
        q_if.out_ready = 1'b0;
        q_if.in_valid  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            q_if.pc = 16'(16'hA000 + g * 16'h1000);
            step();
        end
        chk("pre_flush_count", 64'(q_if.count), 64'd3);
        flush          = 1'b1;
        q_if.out_ready = 1'b1;
        q_if.pc        = 16'h7000;
        step();
        flush         = 1'b0;
        q_if.in_valid = 1'b0;
        chk("flush_count",  64'(q_if.count), 64'd0);
        chk("flush_ovalid", 64'(q_if.out_valid), 64'd0);
        chk("flush_pc",     q_if.pc_to_dec, 64'd0);
        chk("flush_iready", 64'(q_if.in_ready), 64'd1);
        step();
        chk("flush_stays_empty", 64'(q_if.out_valid), 64'd0);
        q_if.out_ready = 1'b0;
        q_if.in_valid  = 1'b1;
        q_if.pc        = 16'h8000;
        step();
        q_if.in_valid = 1'b0;
        chk("post_flush_count", 64'(q_if.count), 64'd1);
        chk("post_flush_pc",    q_if.pc_to_dec, 64'h8000_8001_8002_8003);

        // Reset mid-stream discards contents
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_count",  64'(q_if.count), 64'd0);
        chk("mid_rst_ovalid", 64'(q_if.out_valid), 64'd0);
        chk("mid_rst_pc",     q_if.pc_to_dec, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
